// File: rtl/rf_scoreboard.sv
// rf_scoreboard: register file with write-to-read bypass and a pending-write scoreboard for RAW hazard detection
//   clk, reset                       : clock, synchronous active-high reset
//   rs/rt -> outA/outB, busyA/busyB  : two combinational read ports with pending flags
//   write_enabled, rd, write_data    : writeback port (stores data, releases the register)
//   reserve_en, reserve_addr         : decode port marking a register as pending
//   busy_count                       : number of registers currently pending
module rf_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rs,
    input  logic [ADDR_WIDTH-1:0] rt,
    output logic [DATA_WIDTH-1:0] outA,
    output logic [DATA_WIDTH-1:0] outB,
    output logic                  busyA,
    output logic                  busyB,
    input  logic                  write_enabled,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reserve_en,
    input  logic [ADDR_WIDTH-1:0] reserve_addr,
    output logic [ADDR_WIDTH:0]   busy_count
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]      busy_q, busy_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  we, re, inc, dec;
    logic                  zero_a, zero_b, byp_a, byp_b;

    always_comb begin
        we     = write_enabled && !reset && !(ZR && rd == '0);
        re     = reserve_en && !reset && !(ZR && reserve_addr == '0);
        mem_d  = mem_q;
        busy_d = busy_q;
        if (we) begin
            mem_d[rd]  = write_data;
            busy_d[rd] = 1'b0;
        end
        // reserve applied after the write so a same-address producer keeps the register pending
        if (re) busy_d[reserve_addr] = 1'b1;
        inc   = re && !busy_q[reserve_addr];
        dec   = we && busy_q[rd] && !(re && reserve_addr == rd);
        cnt_d = cnt_q + {{ADDR_WIDTH{1'b0}}, inc} - {{ADDR_WIDTH{1'b0}}, dec};
        zero_a = ZR && rs == '0;
        zero_b = ZR && rt == '0;
        byp_a  = we && rd == rs;
        byp_b  = we && rd == rt;
        outA   = zero_a ? '0 : byp_a ? write_data : mem_q[rs];
        outB   = zero_b ? '0 : byp_b ? write_data : mem_q[rt];
        // a bypassed write releases the register unless it is re-reserved in the same cycle
        busyA  = zero_a ? 1'b0 : (byp_a && !(re && reserve_addr == rs)) ? 1'b0 : busy_q[rs];
        busyB  = zero_b ? 1'b0 : (byp_b && !(re && reserve_addr == rt)) ? 1'b0 : busy_q[rt];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q  <= '{default: '0};
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_count = cnt_q;
endmodule
